// File: rtl/alu_pkg.sv
// Shared constants for the ALU command driver: op codes, widths, FSM states.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SRL = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO; full/empty come from read/write pointers with one extra wrap bit.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands, drives them one at a time onto the ALU and
// returns the registered result with its tag on a valid/ready channel.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_zero,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int W = OP_W + 2*DATA_W + TAG_W;

    state_t             state;
    logic [W-1:0]       fifo_wdata;
    logic [W-1:0]       fifo_rdata;
    logic               full;
    logic               empty;
    logic               pop;
    logic [OP_W-1:0]    head_op;
    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;
    logic [TAG_W-1:0]   head_tag;
    logic [TAG_W-1:0]   cur_tag;

    assign cmd_ready  = !full;
    assign fifo_wdata = {cmd_op, cmd_a, cmd_b, cmd_tag};
    assign {head_op, head_a, head_b, head_tag} = fifo_rdata;
    assign pop  = (state == ST_ISSUE);
    assign busy = (state != ST_IDLE) || !empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            cur_tag   <= '0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_zero  <= 1'b0;
            rsp_tag   <= '0;
            done_cnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!empty)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    alu_a   <= head_a;
                    alu_b   <= head_b;
                    alu_op  <= head_op;
                    cur_tag <= head_tag;
                    state   <= ST_CAPTURE;
                end
                // ALU is combinational: its result settles within one cycle.
                ST_CAPTURE: begin
                    rsp_res   <= alu_res;
                    rsp_zero  <= alu_zero;
                    rsp_tag   <= cur_tag;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNT_W'(1);
                        state     <= empty ? ST_IDLE : ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
